// File: rtl/pipe_controller_if.sv
// Control bundle between the pipelined MIPS controller and its datapath.
// master: the controller (decodes instr_d, drives stage controls).
// slave:  the datapath (supplies instr_d, consumes controls).
interface pipe_controller_if;
    logic [31:0] instr_d;
    logic        stall;
    logic [2:0]  d_branch_op;
    logic        d_jump;
    logic        d_jr;
    logic        d_sign_ext;
    logic [2:0]  e_alu_op;
    logic        e_alu_src;
    logic [2:0]  e_md_op;
    logic        m_mem_write;
    logic [2:0]  m_mem_op;
    logic [4:0]  e_dst;
    logic [4:0]  m_dst;
    logic [4:0]  w_dst;
    logic [1:0]  m_reg_src;
    logic [1:0]  w_reg_src;
    logic        w_reg_write;
    logic        md_busy;

    modport master (
        input  instr_d,
        output stall, d_branch_op, d_jump, d_jr, d_sign_ext,
        output e_alu_op, e_alu_src, e_md_op, m_mem_write, m_mem_op,
        output e_dst, m_dst, w_dst, m_reg_src, w_reg_src, w_reg_write, md_busy
    );

    modport slave (
        output instr_d,
        input  stall, d_branch_op, d_jump, d_jr, d_sign_ext,
        input  e_alu_op, e_alu_src, e_md_op, m_mem_write, m_mem_op,
        input  e_dst, m_dst, w_dst, m_reg_src, w_reg_src, w_reg_write, md_busy
    );
endinterface

// File: rtl/pipe_controller.sv
// Pipelined control unit for the five-stage MIPS core: D-stage decode, E/M/W control
// registers, Tuse/Tnew hazard stall and per-stage destination registers for forwarding.
// Optional multiply/divide busy tracker compiled in with PIPE_CTRL_MDU_EN.
module pipe_controller #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input logic               clk,
    input logic               reset,
    pipe_controller_if.master bus
);

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic [2:0] md_op;
        logic       mem_write;
        logic [2:0] mem_op;
        logic [1:0] reg_src;
        logic [4:0] dst;
        logic [1:0] tnew;
    } e_ctrl_t;

    typedef struct packed {
        logic       mem_write;
        logic [2:0] mem_op;
        logic [1:0] reg_src;
        logic [4:0] dst;
        logic [1:0] tnew;
    } m_ctrl_t;

    typedef struct packed {
        logic [1:0] reg_src;
        logic [4:0] dst;
    } w_ctrl_t;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;

    assign op    = bus.instr_d[31:26];
    assign rs    = bus.instr_d[25:21];
    assign rt    = bus.instr_d[20:16];
    assign rd    = bus.instr_d[15:11];
    assign funct = bus.instr_d[5:0];
    // Shift amount is consumed by the datapath, not by control.
    assign unused_shamt = ^bus.instr_d[10:6];

    e_ctrl_t    dec;
    logic [2:0] branch_op;
    logic       jump, jr, sign_ext;
    logic       use_rs, use_rt;
    logic [1:0] tuse_rs, tuse_rt;

    // D-stage decode: E-bound control bundle, D-only controls and source-use times.
    always_comb begin
        dec       = '0;
        branch_op = 3'd0;
        jump      = 1'b0;
        jr        = 1'b0;
        sign_ext  = 1'b0;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        tuse_rs   = 2'd0;
        tuse_rt   = 2'd0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22: begin
                        dec.alu_op = (funct == 6'h22) ? 3'd1 : 3'd0;
                        dec.dst    = rd;
                        dec.tnew   = 2'd1;
                        use_rs     = 1'b1;
                        use_rt     = 1'b1;
                        tuse_rs    = 2'd1;
                        tuse_rt    = 2'd1;
                    end
                    6'h00: begin
                        dec.alu_op = 3'd4;
                        dec.dst    = rd;
                        dec.tnew   = 2'd1;
                        use_rt     = 1'b1;
                        tuse_rt    = 2'd1;
                    end
                    6'h08: begin
                        jr     = 1'b1;
                        use_rs = 1'b1;
                    end
`ifdef PIPE_CTRL_MDU_EN
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        dec.md_op = 3'd1 + {1'b0, funct[1:0]};
                        use_rs    = 1'b1;
                        use_rt    = 1'b1;
                        tuse_rs   = 2'd1;
                        tuse_rt   = 2'd1;
                    end
                    6'h10, 6'h12: begin
                        dec.md_op   = funct[1] ? 3'd6 : 3'd5;
                        dec.dst     = rd;
                        dec.reg_src = 2'd3;
                        dec.tnew    = 2'd1;
                    end
                    6'h11, 6'h13: begin
                        dec.md_op = 3'd7;
                        use_rs    = 1'b1;
                        tuse_rs   = 2'd1;
                    end
`endif
                    default: ;
                endcase
            end
            6'h0d, 6'h0f: begin
                dec.alu_op  = (op == 6'h0f) ? 3'd5 : 3'd3;
                dec.alu_src = 1'b1;
                dec.dst     = rt;
                dec.tnew    = 2'd1;
                use_rs      = (op == 6'h0d);
                tuse_rs     = 2'd1;
            end
            6'h04, 6'h05: begin
                branch_op  = (op == 6'h04) ? 3'd5 : 3'd4;
                sign_ext   = 1'b1;
                dec.alu_op = 3'd1;
                use_rs     = 1'b1;
                use_rt     = 1'b1;
            end
            6'h06, 6'h07: begin
                branch_op = (op == 6'h06) ? 3'd3 : 3'd2;
                sign_ext  = 1'b1;
                use_rs    = 1'b1;
            end
            6'h01: begin
                // Only bltz (rt=0) and bgez (rt=1) are supported REGIMM forms.
                if (rt == 5'd0 || rt == 5'd1) begin
                    branch_op = 3'd1;
                    sign_ext  = 1'b1;
                    use_rs    = 1'b1;
                end
            end
            6'h02: jump = 1'b1;
            6'h03: begin
                jump        = 1'b1;
                dec.dst     = 5'd31;
                dec.reg_src = 2'd2;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                unique case (op)
                    6'h23:   dec.mem_op = 3'd0;
                    6'h21:   dec.mem_op = 3'd1;
                    6'h25:   dec.mem_op = 3'd2;
                    6'h20:   dec.mem_op = 3'd3;
                    default: dec.mem_op = 3'd4;
                endcase
                dec.alu_src = 1'b1;
                dec.reg_src = 2'd1;
                dec.dst     = rt;
                dec.tnew    = 2'd2;
                sign_ext    = 1'b1;
                use_rs      = 1'b1;
                tuse_rs     = 2'd1;
            end
            6'h28, 6'h29, 6'h2b: begin
                unique case (op)
                    6'h2b:   dec.mem_op = 3'd5;
                    6'h29:   dec.mem_op = 3'd6;
                    default: dec.mem_op = 3'd7;
                endcase
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                sign_ext      = 1'b1;
                use_rs        = 1'b1;
                use_rt        = 1'b1;
                tuse_rs       = 2'd1;
                tuse_rt       = 2'd2;
            end
            default: ;
        endcase
    end

    e_ctrl_t e_q, e_d;
    m_ctrl_t m_q, m_d;
    w_ctrl_t w_q, w_d;
    logic    hazard;
    logic    md_stall;
    logic    stall;

    // Data hazard: a producer in E or M whose result is not ready by the consumer's Tuse.
    always_comb begin
        hazard = 1'b0;
        if (use_rs && rs != 5'd0) begin
            if (e_q.dst == rs && e_q.tnew > tuse_rs) hazard = 1'b1;
            if (m_q.dst == rs && m_q.tnew > tuse_rs) hazard = 1'b1;
        end
        if (use_rt && rt != 5'd0) begin
            if (e_q.dst == rt && e_q.tnew > tuse_rt) hazard = 1'b1;
            if (m_q.dst == rt && m_q.tnew > tuse_rt) hazard = 1'b1;
        end
    end

    assign stall = hazard | md_stall;

    // Next pipeline state: bubble into E on stall; M and W always advance.
    always_comb begin
        e_d           = stall ? '0 : dec;
        m_d.mem_write = e_q.mem_write;
        m_d.mem_op    = e_q.mem_op;
        m_d.reg_src   = e_q.reg_src;
        m_d.dst       = e_q.dst;
        m_d.tnew      = (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0;
        w_d.reg_src   = m_q.reg_src;
        w_d.dst       = m_q.dst;
    end

    // E/M/W control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef PIPE_CTRL_MDU_EN
    logic [CNT_W-1:0] md_cnt_q;
    logic             e_md_start;

    assign e_md_start = (e_q.md_op != 3'd0) && (e_q.md_op <= 3'd4);
    // Any MDU-class op waits until the unit is idle and no start is about to load it.
    assign md_stall   = (dec.md_op != 3'd0) && ((md_cnt_q != '0) || e_md_start);

    // Busy counter: loaded as a start leaves E, then counts down to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q <= '0;
        end else if (e_md_start) begin
            md_cnt_q <= (e_q.md_op >= 3'd3) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_q <= md_cnt_q - 1'b1;
        end
    end

    assign bus.e_md_op = e_q.md_op;
    assign bus.md_busy = (md_cnt_q != '0);
`else
    logic unused_md;

    assign unused_md   = ^{e_q.md_op, CNT_W'(MULT_CYCLES), CNT_W'(DIV_CYCLES)};
    assign md_stall    = 1'b0;
    assign bus.e_md_op = 3'd0;
    assign bus.md_busy = 1'b0;
`endif

    assign bus.stall       = stall;
    assign bus.d_branch_op = branch_op;
    assign bus.d_jump      = jump;
    assign bus.d_jr        = jr;
    assign bus.d_sign_ext  = sign_ext;
    assign bus.e_alu_op    = e_q.alu_op;
    assign bus.e_alu_src   = e_q.alu_src;
    assign bus.e_dst       = e_q.dst;
    assign bus.m_mem_write = m_q.mem_write;
    assign bus.m_mem_op    = m_q.mem_op;
    assign bus.m_dst       = m_q.dst;
    assign bus.m_reg_src   = m_q.reg_src;
    assign bus.w_dst       = w_q.dst;
    assign bus.w_reg_src   = w_q.reg_src;
    assign bus.w_reg_write = (w_q.dst != 5'd0);

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Pipelined control unit for the five-stage MIPS core. It decodes the instruction in D using the single-cycle controller's control encodings, and carries the control bundle through E, M and W pipeline registers. It computes Tuse/Tnew data-hazard stalls, and it exports per-stage destination registers so the datapath can build forwarding muxes. An optional multiply/divide busy tracker can be compiled in.

## Interface
- MULT_CYCLES, 5, cycles the MDU stays busy after a mult/multu leaves E
- DIV_CYCLES, 10, cycles the MDU stays busy after a div/divu leaves E
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all pipeline control registers
- instr_d  in  32  instruction currently in D
- stall  out  1  freeze PC and F/D register, bubble into E
- d_branch_op  out  3  1 bgez/bltz, 2 bgtz, 3 blez, 4 bne, 5 beq, 0 none
- d_jump / d_jr / d_sign_ext  out  1 each  D-stage control
- e_alu_op  out  3  0 add, 1 sub, 3 or, 4 sll, 5 lui
- e_alu_src  out  1  immediate select
- e_md_op  out  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi/mtlo (rs selects)
- m_mem_write  out  1  store enable
- m_mem_op  out  3  0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5 sw, 6 sh, 7 sb
- e_dst / m_dst / w_dst  out  5 each  write-register address in that stage, 0 if none
- m_reg_src / w_reg_src  out  2 each  0 ALU, 1 memory, 2 PC+8, 3 HI/LO
- w_reg_write  out  1  register-file write enable
- md_busy  out  1  MDU in progress

## Operation
- Decode (combinational, D):
  - Instruction set: add, sub, sll, jr, ori, lui, beq, bne, bgtz, blez, bgez/bltz, all loads and stores, j, jal.
  - Unknown opcodes decode as nop: all enables 0, dst 0.
- Destination:
  - R-type writes rd.
  - I-type writes rt.
  - jal writes 31.
  - Instructions that do not write use dst 0, and dst 0 forces reg_write 0.
- Tuse:
  - Branches and jr: rs Tuse 0; branch rt Tuse 0.
  - ALU and address rs: Tuse 1; R-type rt: Tuse 1.
  - Store rt: Tuse 2.
  - Any field not read by the instruction never causes a stall.
- Tnew, assigned on entry to E:
  - Load: 2.
  - ALU and mf*: 1.
  - jal: 0.
  - Tnew decrements per stage, saturating at 0.
- Stall condition, per source src ∈ {rs, rt}, for X ∈ {E, M}: dst_X == src, src != 0, and Tnew_X > Tuse_src.
- While stalled:
  - E receives the all-zero bubble.
  - M and W advance normally.
  - D outputs stay valid for the held instruction.
- Reset (async, active-low): all E/M/W registers, the busy counter and all registered outputs go to 0. stall and the D-stage outputs follow instr_d combinationally.

## Timing
- D-stage outputs: zero latency.
- e_* outputs: one cycle after D.
- m_*: two cycles after D.
- w_*: three cycles after D.
- Stall is combinational from instr_d and the current E/M state, within the same cycle.
- lw followed by a dependent ALU op: 1 stall.
- lw followed by a dependent branch: 2 stalls.
- ALU op followed by a dependent branch: 1 stall.
- jal followed by jr $31: 0 stalls.

## Configuration
- PIPE_CTRL_MDU_EN defined:
  - mult/multu/div/divu/mfhi/mflo/mthi/mtlo are decoded.
  - A start in E loads the counter with MULT_CYCLES or DIV_CYCLES on the next edge.
  - The counter decrements each cycle; md_busy = (count != 0).
  - Any MDU-class instruction in D stalls while md_busy or while a start sits in E.
  - A second start in E while busy is impossible, because the stall rule prevents it.
- PIPE_CTRL_MDU_EN undefined:
  - MDU opcodes decode as nop.
  - e_md_op = 0, md_busy = 0, and no counter exists.

## Test plan
- Reset low mid-stream, with lw in E and sw in M -> all e_/m_/w_ outputs 0 immediately; stall 0 for a nop in D.
- lw $1,0($0) then add $2,$1,$1 -> stall=1 for exactly one cycle, then w_dst=1 and w_reg_src=1 two cycles after the bubble.
- lw $3 then beq $3,$0 -> stall for two consecutive cycles, then d_branch_op=5 proceeds.
- jal then jr $31 -> no stall; w_dst=31, w_reg_src=2.
- ori $0,$0,5 followed by add $4,$0,$0 -> no stall; w_reg_write=0.
- With PIPE_CTRL_MDU_EN: mult followed by mflo -> stall for MULT_CYCLES+1=6 cycles. With div: 11 cycles. md_busy falls in the same cycle the stall drops.
